// File: rtl/qsub_serial.sv
// Bit-serial sign-magnitude subtractor: c = a - b, one magnitude bit per clock.
// A borrow out of the magnitude pass triggers a serial two's-complement pass.
module qsub_serial #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] c,
    output logic         ovr
);
    localparam int M  = N - 1;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 2);

    // Q only names the binary point; reject values that cannot fit the word
    if (Q < 0 || Q > N - 1) begin : g_q_range
        $error("qsub_serial: Q out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [M-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sa_q, sa_d, sb_q, sb_d;
    logic            carry_q, carry_d, sign_q, sign_d, ovr_p_q, ovr_p_d;
    logic            busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
    logic [N-1:0]    c_q, c_d;
    logic            sub_s, bit_s, cout_s, inv_s, fsign_s;

    // One-bit full adder / full subtractor on the current LSBs
    always_comb begin
        sub_s  = sa_q ^ sb_q;
        bit_s  = a_q[0] ^ b_q[0] ^ carry_q;
        if (sub_s) begin
            cout_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & carry_q);
        end else begin
            cout_s = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        end
        inv_s   = ~res_q[0];
        // A subtraction that cancels exactly must yield +0, never -0
        if (sub_s && (res_q == {M{1'b0}})) begin
            fsign_s = 1'b0;
        end else begin
            fsign_s = sign_q;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        carry_d = carry_q;
        sign_d  = sign_q;
        ovr_p_d = ovr_p_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        c_d     = c_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SUB;
                    a_d     = a[M-1:0];
                    b_d     = b[M-1:0];
                    sa_d    = a[N-1];
                    sb_d    = ~b[N-1];
                    carry_d = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    res_d   = {M{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                res_d   = {bit_s, res_q[M-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cout_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (sub_s && cout_s) begin
                        state_d = NEG;
                        carry_d = 1'b1;
                        sign_d  = ~sa_q;
                        ovr_p_d = 1'b0;
                    end else begin
                        state_d = FIN;
                        sign_d  = sa_q;
                        ovr_p_d = sub_s ? 1'b0 : cout_s;
                    end
                end else begin
                    state_d = SUB;
                end
            end
            NEG: begin
                res_d   = {inv_s ^ carry_q, res_q[M-1:1]};
                carry_d = inv_s & carry_q;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = FIN;
                end else begin
                    state_d = NEG;
                end
            end
            FIN: begin
                c_d     = {fsign_s, res_q};
                ovr_d   = ovr_p_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= {M{1'b0}};
            b_q     <= {M{1'b0}};
            res_q   <= {M{1'b0}};
            cnt_q   <= {CW{1'b0}};
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
            ovr_p_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= {N{1'b0}};
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            sign_q  <= sign_d;
            ovr_p_q <= ovr_p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_q     <= c_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;
    assign ovr  = ovr_q;
endmodule
